sprite_mover: RTL

Parametrised sprite position controller for the VGA game. It updates a sprite's on-screen position from the five push-buttons on a divided update tick, using a clock enable rather than a derived clock. Held buttons accelerate the sprite, screen edges either clamp or wrap, and the block produces a registered hit flag for the draw logic. It sits between the button inputs and the drawing logic, in the 106 MHz pixel clock domain.

---
 rtl/game_pkg.sv | 23 ++
 rtl/axis_mover.sv | 93 +++++++++
 rtl/sprite_mover.sv | 135 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared screen geometry, coordinate widths, home position and
//               edge-handling mode for the VGA game datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int SCREEN_W = 1440;
  localparam int SCREEN_H = 900;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;
  localparam int HOME_X   = 700;
  localparam int HOME_Y   = 450;

  typedef enum logic [0:0] {
    CLAMP = 1'b0,
    WRAP  = 1'b1
  } edge_mode_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/axis_mover.sv
`default_nettype none
// ============================================================================
// Module      : axis_mover
// Description : One axis of sprite motion. Moves by an accelerating step on
//               each update tick while exactly one direction is held, and
//               clamps or wraps at the axis limits.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_mover
  import game_pkg::*;
#(
  parameter int         W           = 11,
  parameter int         MAX         = 1420,
  parameter int         HOME        = 700,
  parameter int         STEP_MIN    = 1,
  parameter int         STEP_MAX    = 8,
  parameter int         ACCEL_TICKS = 8,
  parameter edge_mode_t EDGE_MODE   = CLAMP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         centre,
  input  logic         neg,
  input  logic         pos,
  output logic [W-1:0] pos_q
);

  localparam int SW = $clog2(STEP_MAX + 1);
  localparam int HW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic [W-1:0]  c_max       = W'(MAX);
  localparam logic [W-1:0]  c_home      = W'(HOME);
  localparam logic [W:0]    c_max_ext   = (W+1)'(MAX);
  localparam logic [SW-1:0] c_step_min  = SW'(STEP_MIN);
  localparam logic [SW-1:0] c_step_max  = SW'(STEP_MAX);
  localparam logic [HW-1:0] c_hold_last = HW'(ACCEL_TICKS - 1);

  logic [SW-1:0] r_step;
  logic [HW-1:0] r_hold;

  logic [W:0]   w_pos_ext;
  logic [W:0]   w_step_ext;
  logic [W:0]   w_sum;
  logic         w_under;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_next;

  // Candidate position for this tick; the extra bit exposes overflow/underflow.
  always_comb begin
    w_pos_ext  = {1'b0, pos_q};
    w_step_ext = (W+1)'(r_step);
    w_sum      = w_pos_ext + w_step_ext;
    w_under    = (w_step_ext > w_pos_ext);
    w_diff     = pos_q - W'(r_step);
    w_next     = pos_q;
    if (neg) begin
      if (w_under) w_next = (EDGE_MODE == WRAP) ? c_max : '0;
      else         w_next = w_diff;
    end else if (pos) begin
      if (w_sum > c_max_ext) w_next = (EDGE_MODE == WRAP) ? '0 : c_max;
      else                   w_next = w_sum[W-1:0];
    end
  end

  // Position, step and hold counter advance only on the update tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= c_home;
      r_step <= c_step_min;
      r_hold <= '0;
    end else if (tick) begin
      if (centre) begin
        pos_q  <= c_home;
        r_step <= c_step_min;
        r_hold <= '0;
      end else if (neg ^ pos) begin
        pos_q <= w_next;
        if (r_hold == c_hold_last) begin
          r_hold <= '0;
          if (r_step != c_step_max) r_step <= r_step + 1'b1;
        end else begin
          r_hold <= r_hold + 1'b1;
        end
      end else begin
        r_step <= c_step_min;
        r_hold <= '0;
      end
    end
  end

endmodule : axis_mover
`default_nettype wire

// File: rtl/sprite_mover.sv
`default_nettype none
// ============================================================================
// Module      : sprite_mover
// Description : Sprite position controller. Synchronises the push-buttons,
//               generates the update tick enable, drives two axis movers and
//               produces the registered pixel hit flag and edge flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_mover
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 1666667,
  parameter int X_W         = game_pkg::X_W,
  parameter int Y_W         = game_pkg::Y_W,
  parameter int SCREEN_W    = game_pkg::SCREEN_W,
  parameter int SCREEN_H    = game_pkg::SCREEN_H,
  parameter int SPR_W       = 20,
  parameter int SPR_H       = 20,
  parameter int HOME_X      = game_pkg::HOME_X,
  parameter int HOME_Y      = game_pkg::HOME_Y,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 8,
  parameter int EDGE_MODE   = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           left,
  input  logic           right,
  input  logic           up,
  input  logic           down,
  input  logic           centre,
  input  logic [X_W-1:0] curr_x,
  input  logic [Y_W-1:0] curr_y,
  output logic [X_W-1:0] blkpos_x,
  output logic [Y_W-1:0] blkpos_y,
  output logic           tick,
  output logic           hit,
  output logic [3:0]     at_edge
);

  localparam int X_MAX = SCREEN_W - SPR_W;
  localparam int Y_MAX = SCREEN_H - SPR_H;
  localparam int CW    = $clog2(TICK_DIV);

  localparam logic [CW-1:0]  c_tick_last = CW'(TICK_DIV - 1);
  localparam logic [X_W-1:0] c_x_max     = X_W'(X_MAX);
  localparam logic [Y_W-1:0] c_y_max     = Y_W'(Y_MAX);
  localparam logic [X_W:0]   c_spr_w     = (X_W+1)'(SPR_W);
  localparam logic [Y_W:0]   c_spr_h     = (Y_W+1)'(SPR_H);

  // Button order: {left, right, up, down, centre}
  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [CW-1:0] r_cnt;

  logic w_left, w_right, w_up, w_down, w_centre;
  logic [X_W:0] w_cx, w_bx;
  logic [Y_W:0] w_cy, w_by;

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {left, right, up, down, centre};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_left, w_right, w_up, w_down, w_centre} = r_sync2;

  // Free-running update divider; tick marks its terminal count.
  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= '0;
    else if (r_cnt == c_tick_last) r_cnt <= '0;
    else                         r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == c_tick_last);

  axis_mover #(
    .W           (X_W),
    .MAX         (X_MAX),
    .HOME        (HOME_X),
    .STEP_MIN    (STEP_MIN),
    .STEP_MAX    (STEP_MAX),
    .ACCEL_TICKS (ACCEL_TICKS),
    .EDGE_MODE   (edge_mode_t'(EDGE_MODE))
  ) u_axis_x (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .centre (w_centre),
    .neg    (w_left),
    .pos    (w_right),
    .pos_q  (blkpos_x)
  );

  axis_mover #(
    .W           (Y_W),
    .MAX         (Y_MAX),
    .HOME        (HOME_Y),
    .STEP_MIN    (STEP_MIN),
    .STEP_MAX    (STEP_MAX),
    .ACCEL_TICKS (ACCEL_TICKS),
    .EDGE_MODE   (edge_mode_t'(EDGE_MODE))
  ) u_axis_y (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .centre (w_centre),
    .neg    (w_up),
    .pos    (w_down),
    .pos_q  (blkpos_y)
  );

  assign w_cx = {1'b0, curr_x};
  assign w_bx = {1'b0, blkpos_x};
  assign w_cy = {1'b0, curr_y};
  assign w_by = {1'b0, blkpos_y};

  // Registered hit test; the extra bit keeps the sprite's far edge from wrapping.
  always_ff @(posedge clk) begin
    if (rst) hit <= 1'b0;
    else     hit <= (w_bx <= w_cx) && (w_cx < w_bx + c_spr_w) &&
                    (w_by <= w_cy) && (w_cy < w_by + c_spr_h);
  end

  assign at_edge = {blkpos_x == '0, blkpos_x == c_x_max,
                    blkpos_y == '0, blkpos_y == c_y_max};

endmodule : sprite_mover
`default_nettype wire
